board_io_mmio64: RTL
====================

Name: board_io_mmio64

Overview:
- Parametrised next-generation board I/O peripheral on the 64-bit SRAM-style bus of the n4ddr SoC.
- Maps an 8-word, 64-byte register window at BASE_ADDR with byte-masked writes, registered 1-cycle reads, and 2-flop synchronised inputs.
- Adds per-button debounce, sticky W1C press events, a free-running cycle counter, and a compare-match timer interrupt.

Parameters:
- BASE_ADDR, 64'h64000000, window base; must be 64-byte aligned.
- SW_WIDTH, 16, switch input count, 1..32.
- BTN_WIDTH, 5, button input count, 1..16.
- DEBOUNCE_CYCLES, 100000, consecutive stable cycles before a button change is accepted; must be >= 1.

Ports:
- clka  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- addra  in  64  byte address.
- dina  in  64  write data.
- douta  out  64  read data.
- ena  in  1  access enable.
- wea  in  8  byte write enables; all zero means read.
- seg7_data  out  32  OUT0[31:0].
- LED  out  16  OUT0[47:32].
- STATUS_LED  out  6  OUT0[53:48].
- SW  in  SW_WIDTH  raw switches, asynchronous.
- DIR_BTN  in  BTN_WIDTH  raw buttons, asynchronous.
- irq  out  1  timer interrupt, level.

Behaviour:
- Interface: one clock, clka; reset rst is synchronous and active-high.
- Reset: every register, synchroniser, debounce counter and douta clears to 0. seg7_data, LED, STATUS_LED and irq are 0 the cycle after rst is sampled high. CYCLE reads 0 on the first edge after reset deasserts.
- Decode:
  - hit = (addra[63:6] == BASE_ADDR[63:6]).
  - idx = addra[5:3]; addra[2:0] is ignored.
- Register map, by idx:
  - 0 OUT0, RW, all 64 bits stored.
  - 1 CYCLE, RO; increments by 1 every non-reset cycle and wraps at 2^64-1 → 0.
  - 2 INPUT, RO: [SW_WIDTH-1:0] = synced SW; [32 +: BTN_WIDTH] = debounced buttons; other bits 0.
  - 3 BTN_EVT, W1C: [BTN_WIDTH-1:0] sticky press events.
  - 4 TCMP, RW, 64-bit compare value.
  - 5 TCTRL: bit0 EN (RW); bit1 PEND (W1C); other bits read 0.
  - 6–7 reserved: read 0, writes ignored.
- Write:
  - Occurs when ena && hit && idx is writable.
  - Each byte b updates only if wea[b]; the update lands at the sampling edge.
  - W1C bits clear only where the byte is enabled and the dina bit is 1.
  - Writes to RO or reserved registers, and all misses, are ignored.
- Read:
  - When ena is high, douta <= selected register at that edge, or 0 on a miss. Data is visible the next cycle.
  - douta holds its value while ena is low.
  - Read-first: a read returns pre-write contents, including during a simultaneous write to the same register.
  - A read of CYCLE returns the count before that edge's increment.
- Inputs: SW and DIR_BTN each pass through a 2-flop synchroniser; synced values are 2 cycles behind the pins.
- Debounce, per button:
  - Counter resets to 0 whenever synced == debounced.
  - Otherwise it counts up; when it reaches DEBOUNCE_CYCLES-1, debounced <= synced and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES produces no change.
- Button events: a debounced 0→1 transition sets BTN_EVT[i]. Set wins over a same-cycle W1C.
- Timer:
  - PEND sets on the edge where EN && CYCLE == TCMP, using pre-increment values.
  - Set wins over a same-cycle W1C.
  - Clearing EN does not clear PEND.
  - irq = PEND.
- Wrap: a TCMP behind CYCLE matches only after the 64-bit wrap.
- Reset mid-operation: any pending event or in-flight read is discarded; douta = 0 the next cycle.

Test Plan:
- Reset then read idx 1 twice, 10 cycles apart → second value minus first value = 10. Read of idx 6 → 0. Read at BASE_ADDR+64 → 0.
- Write OUT0 = 64'h0011_2233_4455_6677 with wea = 8'hFF, then write dina = 64'hFFFF…FF with wea = 8'h01 → seg7_data = 32'h445566FF, LED = 16'h2233, STATUS_LED = 6'h11. A same-cycle read of idx 0 returns the old value.
- With DEBOUNCE_CYCLES = 4:
  - DIR_BTN[2] high for 3 cycles then low → INPUT and BTN_EVT unchanged.
  - DIR_BTN[2] held high → INPUT[34] = 1 and BTN_EVT = 5'b00100 six cycles after the pin rises.
  - W1C write of 1 → reads 0.
- Set SW = 16'hA5A5 → INPUT[15:0] = 16'hA5A5 three cycles later; no debounce applies.
- TCMP = CYCLE + 20, EN = 1 → irq rises exactly when CYCLE reaches TCMP. W1C of PEND on the match edge → PEND stays 1. A later W1C clears irq.
- Assert rst while PEND = 1 and BTN_EVT ≠ 0 → all outputs, registers and douta are 0 the cycle after rst is sampled.

Source files
------------

// File: rtl/board_io_mmio64.sv
// Board I/O peripheral on the 64-bit SRAM-style bus: byte-masked register window,
// synchronised switches, debounced buttons with sticky press events, cycle counter and compare timer.
module board_io_mmio64 #(
    parameter logic [63:0] BASE_ADDR       = 64'h64000000,
    parameter int          SW_WIDTH        = 16,
    parameter int          BTN_WIDTH       = 5,
    parameter int          DEBOUNCE_CYCLES = 100000
) (
    input  logic                 clka,
    input  logic                 rst,
    input  logic [63:0]          addra,
    input  logic [63:0]          dina,
    output logic [63:0]          douta,
    input  logic                 ena,
    input  logic [7:0]           wea,
    output logic [31:0]          seg7_data,
    output logic [15:0]          LED,
    output logic [5:0]           STATUS_LED,
    input  logic [SW_WIDTH-1:0]  SW,
    input  logic [BTN_WIDTH-1:0] DIR_BTN,
    output logic                 irq
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [2:0] IDX_OUT0  = 3'd0;
    localparam logic [2:0] IDX_CYCLE = 3'd1;
    localparam logic [2:0] IDX_INPUT = 3'd2;
    localparam logic [2:0] IDX_EVT   = 3'd3;
    localparam logic [2:0] IDX_TCMP  = 3'd4;
    localparam logic [2:0] IDX_TCTRL = 3'd5;

    function automatic logic [63:0] byte_merge(input logic [63:0] old_v,
                                               input logic [63:0] new_v,
                                               input logic [7:0]  we);
        for (int b = 0; b < 8; b++)
            byte_merge[8*b +: 8] = we[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
    endfunction

    // Bits a W1C write clears: set in dina and inside an enabled byte.
    function automatic logic [63:0] w1c_mask(input logic [63:0] din,
                                             input logic [7:0]  we);
        for (int b = 0; b < 8; b++)
            w1c_mask[8*b +: 8] = we[b] ? din[8*b +: 8] : 8'h00;
    endfunction

    logic [63:0]          out0, cycle, tcmp, rdata;
    logic                 t_en, t_pend, t_en_nxt, t_pend_nxt, match;
    logic [SW_WIDTH-1:0]  sw_s1, sw_s2;
    logic [BTN_WIDTH-1:0] btn_s1, btn_s2, btn_db, btn_db_nxt, btn_evt, btn_evt_nxt, evt_clr;
    logic [CNT_W-1:0]     db_cnt [BTN_WIDTH];
    logic [CNT_W-1:0]     db_cnt_nxt [BTN_WIDTH];
    logic [63:0]          clr_mask;
    logic                 hit, acc, wr_out0, wr_evt, wr_tcmp, wr_tctrl;
    logic [2:0]           idx;
    logic                 unused_addr_bits;

    assign hit              = (addra[63:6] == BASE_ADDR[63:6]);
    assign idx              = addra[5:3];
    assign unused_addr_bits = ^addra[2:0];
    assign acc              = ena && hit;
    assign wr_out0          = acc && (idx == IDX_OUT0);
    assign wr_evt           = acc && (idx == IDX_EVT);
    assign wr_tcmp          = acc && (idx == IDX_TCMP);
    assign wr_tctrl         = acc && (idx == IDX_TCTRL);
    assign clr_mask         = w1c_mask(dina, wea);

    always_comb begin
        btn_db_nxt = btn_db;
        for (int i = 0; i < BTN_WIDTH; i++) begin
            db_cnt_nxt[i] = db_cnt[i];
            if (btn_s2[i] == btn_db[i]) begin
                db_cnt_nxt[i] = '0;
            end else if (db_cnt[i] == CNT_MAX) begin
                btn_db_nxt[i] = btn_s2[i];
                db_cnt_nxt[i] = '0;
            end else begin
                db_cnt_nxt[i] = db_cnt[i] + 1'b1;
            end
        end
    end

    // A new press sets its event even if the same edge carries a W1C for it.
    always_comb begin
        evt_clr     = wr_evt ? clr_mask[BTN_WIDTH-1:0] : '0;
        btn_evt_nxt = (btn_db_nxt & ~btn_db) | (btn_evt & ~evt_clr);
    end

    always_comb begin
        match      = t_en && (cycle == tcmp);
        t_en_nxt   = (wr_tctrl && wea[0]) ? dina[0] : t_en;
        t_pend_nxt = match | (t_pend & ~(wr_tctrl && clr_mask[1]));
    end

    always_comb begin
        rdata = '0;
        case (idx)
            IDX_OUT0:  rdata = out0;
            IDX_CYCLE: rdata = cycle;
            IDX_INPUT: begin
                rdata[SW_WIDTH-1:0]     = sw_s2;
                rdata[32 +: BTN_WIDTH]  = btn_db;
            end
            IDX_EVT:   rdata[BTN_WIDTH-1:0] = btn_evt;
            IDX_TCMP:  rdata = tcmp;
            IDX_TCTRL: rdata[1:0] = {t_pend, t_en};
            default:   rdata = '0;
        endcase
    end

    always_ff @(posedge clka) begin
        if (rst) begin
            out0    <= '0;
            cycle   <= '0;
            tcmp    <= '0;
            t_en    <= 1'b0;
            t_pend  <= 1'b0;
            sw_s1   <= '0;
            sw_s2   <= '0;
            btn_s1  <= '0;
            btn_s2  <= '0;
            btn_db  <= '0;
            btn_evt <= '0;
            douta   <= '0;
            for (int i = 0; i < BTN_WIDTH; i++)
                db_cnt[i] <= '0;
        end else begin
            cycle   <= cycle + 64'd1;
            sw_s1   <= SW;
            sw_s2   <= sw_s1;
            btn_s1  <= DIR_BTN;
            btn_s2  <= btn_s1;
            btn_db  <= btn_db_nxt;
            btn_evt <= btn_evt_nxt;
            t_en    <= t_en_nxt;
            t_pend  <= t_pend_nxt;
            for (int i = 0; i < BTN_WIDTH; i++)
                db_cnt[i] <= db_cnt_nxt[i];
            if (wr_out0)
                out0 <= byte_merge(out0, dina, wea);
            if (wr_tcmp)
                tcmp <= byte_merge(tcmp, dina, wea);
            if (ena)
                douta <= hit ? rdata : 64'd0;
        end
    end

    assign seg7_data  = out0[31:0];
    assign LED        = out0[47:32];
    assign STATUS_LED = out0[53:48];
    assign irq        = t_pend;

endmodule
